// File: rtl/enc7_led_pkg.sv
// rtl/enc7_led_pkg.sv - shared constants, glyph table and polarity helper for enc7_led
package enc7_led_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    // Active-low glyphs indexed by nibble, bit order {g,f,e,d,c,b,a}
    localparam seg_t GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam seg_t SEG_BLANK_AL = 7'h7F;

    function automatic seg_t seg_polarity(input seg_t glyph, input logic active_low);
        return active_low ? glyph : ~glyph;
    endfunction

endpackage

// File: rtl/enc7_led_if.sv
// rtl/enc7_led_if.sv - nibble/mode input and segment output bundle for one digit
interface enc7_led_if;
    import enc7_led_pkg::*;

    logic [3:0] vinp;
    logic       enchx;
    seg_t       leds;

    modport master (
        output vinp,
        output enchx,
        input  leds
    );

    modport slave (
        input  vinp,
        input  enchx,
        output leds
    );

endinterface

// File: rtl/enc7_led_rom.sv
// rtl/enc7_led_rom.sv - combinational nibble to active-low glyph lookup with decimal blanking
module enc7_led_rom
    import enc7_led_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       enchx_i,
    output seg_t       glyph_o
);

    logic dec_blank;

    assign dec_blank = !enchx_i && (nibble_i > 4'd9);

    always_comb begin
        glyph_o = GLYPH[nibble_i];
        if (dec_blank) begin
            glyph_o = SEG_BLANK_AL;
        end
    end

endmodule

// File: rtl/enc7_led.sv
// rtl/enc7_led.sv - registered 4-bit to 7-segment encoder, one digit per instance
module enc7_led
    import enc7_led_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    enc7_led_if.slave    bus
);

    localparam seg_t SEG_BLANK = seg_polarity(SEG_BLANK_AL, ACTIVE_LOW);

    seg_t glyph_al;
    seg_t leds_d;
    seg_t leds_q;

    enc7_led_rom u_rom (
        .nibble_i (bus.vinp),
        .enchx_i  (bus.enchx),
        .glyph_o  (glyph_al)
    );

    assign leds_d = seg_polarity(glyph_al, ACTIVE_LOW);

    // Reset blanks the display immediately, independent of the clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q <= SEG_BLANK;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign bus.leds = leds_q;

endmodule

// File: tb/tb_enc7_led.sv
// tb/tb_enc7_led.sv - randomized self-checking bench for enc7_led in both polarities
module tb_enc7_led;

    logic clk;
    logic rst;

    enc7_led_if bus_al ();
    enc7_led_if bus_ah ();

    enc7_led #(.ACTIVE_LOW(1'b1)) dut_al (
        .clk (clk),
        .rst (rst),
        .bus (bus_al.slave)
    );

    enc7_led #(.ACTIVE_LOW(1'b0)) dut_ah (
        .clk (clk),
        .rst (rst),
        .bus (bus_ah.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] ref_tbl [16];

    initial begin
        ref_tbl[0]  = 7'h40; ref_tbl[1]  = 7'h79; ref_tbl[2]  = 7'h24; ref_tbl[3]  = 7'h30;
        ref_tbl[4]  = 7'h19; ref_tbl[5]  = 7'h12; ref_tbl[6]  = 7'h02; ref_tbl[7]  = 7'h78;
        ref_tbl[8]  = 7'h00; ref_tbl[9]  = 7'h10; ref_tbl[10] = 7'h08; ref_tbl[11] = 7'h03;
        ref_tbl[12] = 7'h46; ref_tbl[13] = 7'h21; ref_tbl[14] = 7'h06; ref_tbl[15] = 7'h0E;
    end

    function automatic logic [6:0] ref_al(input int v, input bit hex);
        if (!hex && v >= 10) return 7'h7F;
        return ref_tbl[v];
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int v, input bit hex);
        bus_al.vinp  = v[3:0];
        bus_al.enchx = hex;
        bus_ah.vinp  = v[3:0];
        bus_ah.enchx = hex;
    endtask

    task automatic step(input int v, input bit hex, input string tag);
        drive(v, hex);
        @(posedge clk);
        #1;
        check(tag, bus_al.leds, ref_al(v, hex));
        check({tag, "_ah"}, bus_ah.leds, ~ref_al(v, hex));
    endtask

    initial begin
        rst = 1'b1;
        drive($urandom_range(0, 15), 1'b1);
        #1;
        check("rst_noclk", bus_al.leds, 7'h7F);
        check("rst_noclk_ah", bus_ah.leds, 7'h00);

        @(negedge clk);
        drive(0, 1'b1);
        rst = 1'b0;
        #1;
        check("rel_hold", bus_al.leds, 7'h7F);
        @(posedge clk);
        #1;
        check("rel_first", bus_al.leds, 7'h40);

        for (int v = 0; v < 16; v++) step(v, 1'b1, $sformatf("hex_%0d", v));
        step(3, 1'b1, "spot_3");
        step(11, 1'b1, "spot_b");
        for (int v = 0; v < 16; v++) step(v, 1'b0, $sformatf("dec_%0d", v));

        step(8, 1'b1, "hold8");
        step(10, 1'b1, "toggle_hex_a");
        step(10, 1'b0, "toggle_dec_a");

        step(1, 1'b1, "ah_one");
        check("ah_one_val", bus_ah.leds, 7'h06);

        step(8, 1'b1, "pre_rst8");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst", bus_al.leds, 7'h7F);
        check("mid_rst_ah", bus_ah.leds, 7'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held", bus_al.leds, 7'h7F);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel_hold", bus_al.leds, 7'h7F);
        @(posedge clk);
        #1;
        check("rst_rel_load", bus_al.leds, 7'h00);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 15), 1'($urandom_range(0, 1)), $sformatf("rnd_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
